note_scroll_ctrl: RTL and testbench

Upstream sequencer for the lane display stage. Generates the frame tick, runs the startdraw/all_done handshake once per frame, and advances the scroll offset. At each row wrap it loads a new note-row code from an LFSR pattern source. Its outputs feed the display stage's startdraw, offset and row_1 inputs.

---
 rtl/note_scroll_ctrl_if.sv | 26 ++
 rtl/note_scroll_ctrl.sv | 98 +++++++++
 tb/tb_note_scroll_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/note_scroll_ctrl_if.sv
// note_scroll_ctrl_if: bundle between note_scroll_ctrl and the game/display side.
//   start      game running level (to controller)
//   all_done   display stage frame-complete level (to controller)
//   pause      freeze frame ticks, only with SCROLL_PAUSE_EN (to controller)
//   startdraw  draw request level (from controller)
//   offset     scroll offset within current row (from controller)
//   row_1      note-row code, 0 empty, 1..4 lane (from controller)
//   busy       handshake/advance in progress (from controller)
//   overrun    sticky missed-tick flag (from controller)
interface note_scroll_ctrl_if;
  logic       start;
  logic       all_done;
  logic       startdraw;
  logic [5:0] offset;
  logic [2:0] row_1;
  logic       busy;
  logic       overrun;
`ifdef SCROLL_PAUSE_EN
  logic       pause;
  modport master (input start, all_done, pause, output startdraw, offset, row_1, busy, overrun);
  modport slave  (output start, all_done, pause, input startdraw, offset, row_1, busy, overrun);
`else
  modport master (input start, all_done, output startdraw, offset, row_1, busy, overrun);
  modport slave  (output start, all_done, input startdraw, offset, row_1, busy, overrun);
`endif
endinterface

// File: rtl/note_scroll_ctrl.sv
// note_scroll_ctrl: frame-tick sequencer driving the lane display stage.
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     note_scroll_ctrl_if.master (start, all_done, [pause] in; startdraw,
//           offset, row_1, busy, overrun out)
// Optional macro SCROLL_PAUSE_EN adds bus.pause, which freezes the frame divider.
module note_scroll_ctrl #(
  parameter int         FRAME_DIV  = 833334,
  parameter int         ROW_HEIGHT = 40,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  resetn,
  note_scroll_ctrl_if.master    bus
);
  localparam int DW = $clog2(FRAME_DIV);
  typedef enum logic [2:0] {IDLE, WAIT_TICK, DRAW, RELEASE, ADVANCE} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      lfsr_q, lfsr_d, lfsr_nx;
  logic [5:0]      offset_q, offset_d;
  logic [2:0]      row_q, row_d;
  logic            sd_q, sd_d, busy_q, busy_d, ovr_q, ovr_d;
  logic            run, tick;
`ifdef SCROLL_PAUSE_EN
  assign run = bus.start & ~bus.pause;
`else
  assign run = bus.start;
`endif
  assign tick    = run && (div_q == DW'(FRAME_DIV - 1));
  assign lfsr_nx = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_comb begin
    div_d    = !bus.start ? '0 : !run ? div_q : tick ? '0 : div_q + 1'b1;
    state_d  = state_q;
    sd_d     = sd_q;
    offset_d = offset_q;
    row_d    = row_q;
    lfsr_d   = lfsr_q;
    // a tick outside WAIT_TICK is dropped, only flagged
    ovr_d    = ovr_q | (tick && (state_q inside {DRAW, RELEASE, ADVANCE}));
    case (state_q)
      IDLE:      state_d = WAIT_TICK;
      WAIT_TICK: if (tick) begin
        state_d = DRAW;
        sd_d    = 1'b1;
      end
      DRAW:      if (bus.all_done) begin
        state_d = RELEASE;
        sd_d    = 1'b0;
      end
      RELEASE:   if (!bus.all_done) state_d = ADVANCE;
      ADVANCE: begin
        state_d = WAIT_TICK;
        if (offset_q == 6'(ROW_HEIGHT - 1)) begin
          offset_d = '0;
          lfsr_d   = lfsr_nx;
          row_d    = (lfsr_nx[2:0] <= 3'd4) ? lfsr_nx[2:0] : 3'd0;
        end else
          offset_d = offset_q + 1'b1;
      end
      default:   state_d = IDLE;
    endcase
    // stopping the game overrides everything except the LFSR, so the pattern continues
    if (!bus.start) begin
      state_d  = IDLE;
      sd_d     = 1'b0;
      offset_d = '0;
      row_d    = '0;
      ovr_d    = 1'b0;
    end
    busy_d = state_d inside {DRAW, RELEASE, ADVANCE};
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      div_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      offset_q <= '0;
      row_q    <= '0;
      sd_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      lfsr_q   <= lfsr_d;
      offset_q <= offset_d;
      row_q    <= row_d;
      sd_q     <= sd_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  assign bus.startdraw = sd_q;
  assign bus.offset    = offset_q;
  assign bus.row_1     = row_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_note_scroll_ctrl.sv
// tb_note_scroll_ctrl: scoreboard bench for note_scroll_ctrl with FRAME_DIV=4, ROW_HEIGHT=4.
module tb_note_scroll_ctrl;
  typedef struct {int off; int row; int ovr;} exp_t;
  logic clk = 1'b0;
  logic resetn;
  logic man_done;
  logic q1 = 1'b0, q2 = 1'b0;
  int   mode;
  int   errors = 0, checks = 0;
  logic prev_busy = 1'b0;
  exp_t q[$];
  note_scroll_ctrl_if bus();
  note_scroll_ctrl #(.FRAME_DIV(4), .ROW_HEIGHT(4), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  always #5 clk = ~clk;
  // display model: mode 0 answers next cycle, mode 2 answers two cycles late, mode 3 manual
  always @(negedge clk) begin
    q2 = q1;
    q1 = bus.startdraw;
  end
  assign bus.all_done = (mode == 3) ? man_done : (mode == 0) ? q1 : q2;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input int o, input int r, input int v);
    q.push_back('{o, r, v});
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", q.size(), 0);
  endtask
  task automatic wait_sd(input int budget);
    int n = 0;
    while (!bus.startdraw && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("startdraw_wait", int'(bus.startdraw), 1);
  endtask
  // monitor: each completed ADVANCE (busy falling while running) is one frame result
  always @(negedge clk) begin
    exp_t e;
    if (prev_busy && !bus.busy && bus.start && resetn) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_frame: offset %0d row_1 %0d with empty queue", bus.offset, bus.row_1);
      end else begin
        e = q.pop_front();
        chk("frame_offset", int'(bus.offset), e.off);
        chk("frame_row_1", int'(bus.row_1), e.row);
        chk("frame_overrun", int'(bus.overrun), e.ovr);
      end
    end
    prev_busy = bus.busy;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    resetn = 1'b0;
    bus.start = 1'b0;
    man_done = 1'b0;
    mode = 2;
`ifdef SCROLL_PAUSE_EN
    bus.pause = 1'b0;
`endif
    step(2);
    chk("rst_startdraw", int'(bus.startdraw), 0);
    chk("rst_offset", int'(bus.offset), 0);
    chk("rst_row_1", int'(bus.row_1), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    resetn = 1'b1;
    step(1);
    // two-cycle display: each frame overlaps the next tick, so overrun goes sticky
    bus.start = 1'b1;
    step(3);
    chk("first_tick_early", int'(bus.startdraw), 0);
    step(1);
    chk("first_tick_latency", int'(bus.startdraw), 1);
    push(1, 0, 1); push(2, 0, 1); push(3, 0, 1); push(0, 2, 1); push(1, 2, 1);
    drain(100);
    bus.start = 1'b0;
    step(2);
    chk("stop_overrun_clear", int'(bus.overrun), 0);
    chk("stop_offset_clear", int'(bus.offset), 0);
    chk("stop_row_clear", int'(bus.row_1), 0);
    // display never answers: startdraw held, ticks become overruns
    mode = 3;
    bus.start = 1'b1;
    wait_sd(10);
    chk("draw_no_overrun_yet", int'(bus.overrun), 0);
    step(10);
    chk("hold_startdraw", int'(bus.startdraw), 1);
    chk("hold_busy", int'(bus.busy), 1);
    chk("hold_overrun", int'(bus.overrun), 1);
    push(1, 0, 1);
    man_done = 1'b1;
    step(1);
    chk("done_to_drop_latency", int'(bus.startdraw), 0);
    man_done = 1'b0;
    drain(20);
    step(8);
    chk("single_advance", int'(bus.offset), 1);
    // all_done stuck high: parked in RELEASE
    wait_sd(10);
    man_done = 1'b1;
    step(1);
    chk("stuck_drop", int'(bus.startdraw), 0);
    step(6);
    chk("stuck_busy", int'(bus.busy), 1);
    chk("stuck_startdraw", int'(bus.startdraw), 0);
    chk("stuck_offset", int'(bus.offset), 1);
    push(2, 0, 1);
    man_done = 1'b0;
    drain(20);
    // start falls together with all_done mid-DRAW: start wins
    wait_sd(10);
    bus.start = 1'b0;
    man_done = 1'b1;
    step(1);
    chk("drop_startdraw", int'(bus.startdraw), 0);
    chk("drop_offset", int'(bus.offset), 0);
    chk("drop_row_1", int'(bus.row_1), 0);
    chk("drop_overrun", int'(bus.overrun), 0);
    chk("drop_busy", int'(bus.busy), 0);
    man_done = 1'b0;
    mode = 0;
    step(1);
    // LFSR continues from 4A: 95 (row 0) then 2A (row 2); frames fit exactly, no overrun
    push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(0, 0, 0);
    push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(0, 2, 0);
    bus.start = 1'b1;
    drain(80);
    // asynchronous reset in the ADVANCE cycle
    wait_sd(10);
    step(2);
    chk("in_advance_busy", int'(bus.busy), 1);
    #1 resetn = 1'b0;
    #1;
    chk("async_startdraw", int'(bus.startdraw), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_offset", int'(bus.offset), 0);
    chk("async_row_1", int'(bus.row_1), 0);
    chk("async_overrun", int'(bus.overrun), 0);
    step(2);
    resetn = 1'b1;
    // reseeded to A5: first wrap loads 4A, row 2
    push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(0, 2, 0);
    drain(60);
    bus.start = 1'b0;
    step(2);
`ifdef SCROLL_PAUSE_EN
    bus.pause = 1'b1;
    bus.start = 1'b1;
    step(20);
    chk("pause_no_draw", int'(bus.startdraw), 0);
    chk("pause_no_busy", int'(bus.busy), 0);
    bus.pause = 1'b0;
    step(3);
    chk("unpause_early", int'(bus.startdraw), 0);
    step(1);
    chk("unpause_latency", int'(bus.startdraw), 1);
    bus.start = 1'b0;
    step(2);
`endif
    chk("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
